csc_rgb_writer: RTL and testbench

CSC_RGB_WRITER -- requirements
Module: csc_rgb_writer

---
 rtl/csc_rgb_writer_pkg.sv | 38 +++
 rtl/csc_core.sv | 63 ++++++
 rtl/csc_rgb_writer.sv | 144 ++++++++++++++
 tb/tb_csc_rgb_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_rgb_writer_pkg.sv
// Shared types, coefficients and sizing for the YUV->RGB SRAM writer.
package csc_rgb_writer_pkg;

  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_AW    = 2;
  localparam int unsigned FIFO_CW    = 3;

  localparam logic [ADDR_W-1:0] RGB_BASE_DEFAULT = 18'd146944;

  localparam logic signed [31:0] COEF_Y  = 32'sd76284;
  localparam logic signed [31:0] COEF_RV = 32'sd104595;
  localparam logic signed [31:0] COEF_GU = 32'sd25624;
  localparam logic signed [31:0] COEF_GV = 32'sd53281;
  localparam logic signed [31:0] COEF_BU = 32'sd132251;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Saturate a signed channel value into 0..255.
  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    if (x < 32'sd0) return 8'd0;
    if (x > 32'sd255) return 8'hFF;
    return x[7:0];
  endfunction

endpackage

// File: rtl/csc_core.sv
// Two-stage colour-space conversion: registered products, then registered clipped RGB.
module csc_core
  import csc_rgb_writer_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       in_valid,
  input  logic [7:0] y_in,
  input  logic [7:0] u_in,
  input  logic [7:0] v_in,
  output logic       out_valid,
  output rgb_t       rgb_out
);

  logic signed [31:0] y_off, u_off, v_off;
  logic signed [31:0] yt_d, yt_q, rv_d, rv_q, gu_d, gu_q, gv_d, gv_q, bu_d, bu_q;
  logic signed [31:0] r_sum, g_sum, b_sum;
  logic               v1_d, v1_q, v2_d, v2_q;
  rgb_t               rgb_d, rgb_q;

  always_comb begin
    y_off = $signed({24'd0, y_in}) - 32'sd16;
    u_off = $signed({24'd0, u_in}) - 32'sd128;
    v_off = $signed({24'd0, v_in}) - 32'sd128;
    yt_d  = COEF_Y  * y_off;
    rv_d  = COEF_RV * v_off;
    gu_d  = COEF_GU * u_off;
    gv_d  = COEF_GV * v_off;
    bu_d  = COEF_BU * u_off;
    v1_d  = in_valid;
    r_sum = (yt_q + rv_q) >>> 16;
    g_sum = (yt_q - gu_q - gv_q) >>> 16;
    b_sum = (yt_q + bu_q) >>> 16;
    rgb_d = '{r: clip8(r_sum), g: clip8(g_sum), b: clip8(b_sum)};
    v2_d  = v1_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      yt_q  <= '0;
      rv_q  <= '0;
      gu_q  <= '0;
      gv_q  <= '0;
      bu_q  <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      yt_q  <= yt_d;
      rv_q  <= rv_d;
      gu_q  <= gu_d;
      gv_q  <= gv_d;
      bu_q  <= bu_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      rgb_q <= rgb_d;
    end
  end

  assign out_valid = v2_q;
  assign rgb_out   = rgb_q;

endmodule

// File: rtl/csc_rgb_writer.sv
// Frame writer: converts YUV pixels to RGB, packs pixel pairs into 3 words and streams them to SRAM.
module csc_rgb_writer
  import csc_rgb_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RGB_BASE   = RGB_BASE_DEFAULT,
  parameter int unsigned       NUM_PIXELS = 76800
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [7:0]        Y_in,
  input  logic [7:0]        U_in,
  input  logic [7:0]        V_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              sram_grant,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PIX_W = $clog2(NUM_PIXELS + 1);

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_p1, wr_p2;
  logic [FIFO_CW-1:0] fifo_cnt_q, fifo_cnt_d, resv_q, resv_d;
  logic               odd_q, odd_d;
  rgb_t               even_q, even_d;
  logic               accept, push, wr_en, last_pix, core_valid;
  logic [3:0]         occupancy;
  rgb_t               core_rgb;

  assign accept   = pix_valid && pix_ready;
  assign push     = core_valid && odd_q;
  assign wr_en    = sram_grant && (fifo_cnt_q != '0);
  assign last_pix = (pix_cnt_q == PIX_W'(NUM_PIXELS - 1));

  csc_core u_core (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .in_valid  (accept),
    .y_in      (Y_in),
    .u_in      (U_in),
    .v_in      (V_in),
    .out_valid (core_valid),
    .rgb_out   (core_rgb)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
      // The final word leaves on the cycle the last FIFO entry is popped with nothing reserved.
      ST_DRAIN: if (resv_q == '0 && fifo_cnt_q == FIFO_CW'(1) && wr_en) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A new pair needs 3 free words; its odd pixel reuses the reservation made by the even one.
  always_comb begin
    occupancy = 4'(fifo_cnt_q) + 4'(resv_q) + (pix_cnt_q[0] ? 4'd0 : 4'd3);
    busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    pix_ready = (state_q == ST_RUN) && (pix_cnt_q < PIX_W'(NUM_PIXELS)) && (occupancy <= 4'd4);
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    addr_d    = addr_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    odd_d     = odd_q;
    even_d    = even_q;
    wr_p1     = wr_ptr_q + FIFO_AW'(1);
    wr_p2     = wr_ptr_q + FIFO_AW'(2);
    if (state_q == ST_IDLE && start) begin
      pix_cnt_d = '0;
      addr_d    = RGB_BASE;
    end
    if (accept) pix_cnt_d = pix_cnt_q + PIX_W'(1);
    resv_d = resv_q + ((accept && !pix_cnt_q[0]) ? FIFO_CW'(3) : FIFO_CW'(0))
                    - (push ? FIFO_CW'(3) : FIFO_CW'(0));
    if (core_valid) begin
      odd_d = !odd_q;
      if (!odd_q) even_d = core_rgb;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = {even_q.r, even_q.g};
      fifo_d[wr_p1]    = {even_q.b, core_rgb.r};
      fifo_d[wr_p2]    = {core_rgb.g, core_rgb.b};
      wr_ptr_d         = wr_ptr_q + FIFO_AW'(3);
    end
    if (wr_en) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      addr_d   = addr_q + ADDR_W'(1);
    end
    fifo_cnt_d = fifo_cnt_q + (push ? FIFO_CW'(3) : FIFO_CW'(0))
                            - (wr_en ? FIFO_CW'(1) : FIFO_CW'(0));
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pix_cnt_q  <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      resv_q     <= '0;
      odd_q      <= 1'b0;
      even_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      resv_q     <= resv_d;
      odd_q      <= odd_d;
      even_q     <= even_d;
      fifo_q     <= fifo_d;
    end
  end

  // The SRAM port follows the grant within the same cycle.
  assign SRAM_we_n       = !wr_en;
  assign SRAM_write_data = wr_en ? fifo_q[rd_ptr_q] : '0;
  assign SRAM_address    = addr_q;

endmodule

// File: tb/tb_csc_rgb_writer.sv
// Scoreboard bench for csc_rgb_writer using a short frame that ends at the top SRAM address.
module tb_csc_rgb_writer;

  localparam int unsigned NPIX      = 64;
  localparam int unsigned NWORDS    = NPIX * 3 / 2;
  localparam logic [17:0] BASE      = 18'(262144 - NWORDS);
  localparam int          STALL_LEN = 20;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  Y_in = '0, U_in = '0, V_in = '0;
  logic        pix_valid = 1'b0;
  logic        sram_grant = 1'b0;
  logic        pix_ready, SRAM_we_n, busy, done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  csc_rgb_writer #(.RGB_BASE(BASE), .NUM_PIXELS(NPIX)) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .start           (start),
    .Y_in            (Y_in),
    .U_in            (U_in),
    .V_in            (V_in),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .sram_grant      (sram_grant),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .busy            (busy),
    .done            (done)
  );

  always #5 Clock = ~Clock;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          wr_mark = 0;
  logic [17:0] last_addr = '0;
  logic        prev_we_low = 1'b0;
  logic [17:0] exp_addr = '0;
  int          grant_mode = 0;
  int          stall_left = 0;
  logic        stall_last = 1'b0;
  logic [7:0]  px_y[NPIX], px_u[NPIX], px_v[NPIX];
  logic [15:0] gold[3];
  logic        use_gold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clipm(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic logic [23:0] model(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    int c, d, e, r, g, b;
    c = int'(y) - 16;
    d = int'(u) - 128;
    e = int'(v) - 128;
    r = (76284 * c + 104595 * e) >>> 16;
    g = (76284 * c - 25624 * d - 53281 * e) >>> 16;
    b = (76284 * c + 132251 * d) >>> 16;
    return {clipm(r), clipm(g), clipm(b)};
  endfunction

  // Every write must be granted and match the head of the expected queue.
  always @(negedge Clock) begin
    if (Resetn) begin
      if (!SRAM_we_n) begin
        chk("write_grant", 64'(sram_grant), 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(SRAM_address), 64'(mon_e[33:16]));
          chk("wr_data", 64'(SRAM_write_data), 64'(mon_e[15:0]));
        end
        wr_cnt++;
        last_addr = SRAM_address;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", 64'({prev_we_low, exp_q.size() == 0}), 64'(2'b11));
      end
      prev_we_low = !SRAM_we_n;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    stall_last = 1'b0;
    if (stall_left > 0) begin
      if (stall_left == STALL_LEN) wr_mark = wr_cnt;
      sram_grant = 1'b0;
      stall_left--;
      stall_last = (stall_left == 0);
    end else if (grant_mode == 2) begin
      sram_grant = 1'($urandom_range(0, 1));
    end else begin
      sram_grant = (grant_mode == 1);
    end
  endtask

  task automatic record_accept(input int idx);
    logic [23:0] c0, c1;
    logic [15:0] w[3];
    if (idx % 2 == 0) return;
    c0 = model(px_y[idx-1], px_u[idx-1], px_v[idx-1]);
    c1 = model(px_y[idx], px_u[idx], px_v[idx]);
    w[0] = {c0[23:16], c0[15:8]};
    w[1] = {c0[7:0], c1[23:16]};
    w[2] = {c1[15:8], c1[7:0]};
    if (use_gold && idx == 1) w = gold;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({exp_addr, w[k]});
      exp_addr = exp_addr + 18'd1;
    end
  endtask

  // kind 0..2: directed first pair with spec words; 3: stall mid-frame; 4: random.
  task automatic run_frame(input int kind, input int mode, input int stop_at);
    int  idx, guard;
    bit  stalled;
    for (int i = 0; i < NPIX; i++) begin
      px_y[i] = 8'($urandom_range(0, 255));
      px_u[i] = 8'($urandom_range(0, 255));
      px_v[i] = 8'($urandom_range(0, 255));
    end
    use_gold = (kind <= 2);
    case (kind)
      0: begin
        px_y[0] = 8'd16;  px_u[0] = 8'd128; px_v[0] = 8'd128;
        px_y[1] = 8'd16;  px_u[1] = 8'd128; px_v[1] = 8'd128;
        gold[0] = 16'h0000; gold[1] = 16'h0000; gold[2] = 16'h0000;
      end
      1: begin
        px_y[0] = 8'd235; px_u[0] = 8'd128; px_v[0] = 8'd128;
        px_y[1] = 8'd16;  px_u[1] = 8'd128; px_v[1] = 8'd128;
        gold[0] = 16'hFEFE; gold[1] = 16'hFE00; gold[2] = 16'h0000;
      end
      2: begin
        px_y[0] = 8'd255; px_u[0] = 8'd255; px_v[0] = 8'd255;
        px_y[1] = 8'd0;   px_u[1] = 8'd128; px_v[1] = 8'd128;
        gold[0] = 16'hFF7D; gold[1] = 16'hFF00; gold[2] = 16'h0000;
      end
      default: ;
    endcase
    exp_addr   = BASE;
    wr_cnt     = 0;
    done_cnt   = 0;
    grant_mode = mode;
    stalled    = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_addr", 64'(SRAM_address), 64'(BASE));
    chk("busy_in_run", 64'(busy), 64'd1);
    idx = 0;
    guard = 0;
    while (idx < stop_at && guard < 5000) begin
      Y_in = px_y[idx];
      U_in = px_u[idx];
      V_in = px_v[idx];
      pix_valid = 1'b1;
      if (kind == 3 && idx == 20 && !stalled) begin
        stalled = 1'b1;
        stall_left = STALL_LEN;
      end
      @(negedge Clock);
      if (stall_last) begin
        chk("stall_ready_low", 64'(pix_ready), 64'd0);
        chk("stall_no_writes", 64'(wr_cnt), 64'(wr_mark));
      end
      if (pix_ready) begin
        record_accept(idx);
        idx++;
      end
      step();
      guard++;
    end
    pix_valid = 1'b0;
    chk("pixels_accepted", 64'(idx), 64'(stop_at));
    if (stop_at < NPIX) return;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      step();
      @(negedge Clock);
      #1;
      guard++;
    end
    repeat (4) step();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("write_count", 64'(wr_cnt), 64'(NWORDS));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("last_addr", 64'(last_addr), 64'h3FFFF);
  endtask

  initial begin
    repeat (2) step();
    @(negedge Clock);
    chk("rst_we_n", 64'(SRAM_we_n), 64'd1);
    chk("rst_addr", 64'(SRAM_address), 64'd0);
    chk("rst_data", 64'(SRAM_write_data), 64'd0);
    chk("rst_ready", 64'(pix_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    step();
    Resetn = 1'b1;
    repeat (3) step();

    run_frame(0, 1, NPIX);
    run_frame(1, 1, NPIX);
    run_frame(2, 2, NPIX);
    run_frame(3, 2, NPIX);

    run_frame(4, 1, 10);
    Resetn = 1'b0;
    #1;
    chk("midrst_we_n", 64'(SRAM_we_n), 64'd1);
    chk("midrst_addr", 64'(SRAM_address), 64'd0);
    chk("midrst_data", 64'(SRAM_write_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(pix_ready), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    prev_we_low = 1'b0;
    repeat (3) begin
      step();
      @(negedge Clock);
      chk("midrst_hold_we_n", 64'(SRAM_we_n), 64'd1);
    end
    step();
    Resetn = 1'b1;
    repeat (5) begin
      step();
      @(negedge Clock);
      chk("no_resume_busy", 64'(busy), 64'd0);
    end
    step();
    run_frame(4, 2, NPIX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
